// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding
//
// Package uart_pkg, used by both the UART transmitter and the receiver.
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LEVEL : level of an idle serial line
//   uart_state_t    : receiver FSM state encoding
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the asynchronous serial line
//
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high reset; both flops load the idle level
//   rxd    in  asynchronous serial input
//   rxd_s  out synchronised serial line (2-cycle latency)
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rxd_s
);

  logic rxd_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= UART_IDLE_LEVEL;
      rxd_s    <= UART_IDLE_LEVEL;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage with mid-bit sampling
//
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits (sense set by PARITY_ODD: 0 = even, 1 = odd).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   RXD        in   asynchronous serial line, idles high
//   rx_data    out  last correctly framed byte, held until the next good frame
//   rx_valid   out  1-cycle pulse when rx_data has just been updated
//   rx_busy    out  high in every state except IDLE
//   frame_err  out  1-cycle pulse when the stop bit was sampled low
//   parity_err out  1-cycle pulse with rx_valid on bad parity (0 without the macro)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [2:0]    IDX_LAST      = 3'(UART_DATA_BITS - 1);

  uart_state_t         state;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                rxd_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd   (RXD),
    .rxd_s (rxd_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
`else
  assign parity_err = 1'b0;
`endif

  // rx_busy is registered alongside every state change so it always equals
  // (state != IDLE) without a decode after the flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_HIGH;
      rx_busy    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        // A line held low out of reset or after a break must return high
        // before a falling edge can count as a start bit.
        WAIT_HIGH: begin
          if (rxd_s == UART_IDLE_LEVEL) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        IDLE: begin
          if (rxd_s != UART_IDLE_LEVEL) begin
            state   <= START;
            rx_busy <= 1'b1;
            cnt     <= '0;
          end
        end
        // Re-check the start bit at its mid-point; a high sample was a glitch.
        START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (rxd_s == UART_IDLE_LEVEL) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == CNT_FULL_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rxd_s;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_FULL_LAST) begin
            cnt        <= '0;
            parity_bit <= rxd_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_FULL_LAST) begin
            cnt <= '0;
            if (rxd_s == UART_IDLE_LEVEL) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err <= ((^shift_reg) ^ parity_bit) != PARITY_ODD;
`endif
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= WAIT_HIGH;
          rx_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Event counters kept by the monitor only; tests compare deltas.
  int         valid_cnt = 0;
  int         fe_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic       last_par = 1'b0;

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .RXD        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      prev_data <= last_data;
      last_data <= rx_data;
      last_par  <= parity_err;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic par, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rxd = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  // Correct parity for the default even sense.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_raw(d, ^d, stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else pass_cnt++;
    total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else pass_cnt++;
    total_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err got %b exp 0", parity_err); else pass_cnt++;
    total_cnt++; if (rx_busy !== 1'b1) $display("FAIL reset_rx_busy got %b exp 1", rx_busy); else pass_cnt++;
    reset = 1'b0;
    idle(6);
    total_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", rx_busy); else pass_cnt++;
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle(2 * C + 4);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL single_valid_pulses got %0d exp 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (last_data !== 8'hA5) $display("FAIL single_data got %h exp a5", last_data); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL single_frame_err got %0d exp 0", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (rx_busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", rx_busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * C + 4);
    total_cnt++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_valid_pulses got %0d exp 2", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (prev_data !== 8'h00) $display("FAIL b2b_first_data got %h exp 00", prev_data); else pass_cnt++;
    total_cnt++; if (last_data !== 8'hFF) $display("FAIL b2b_second_data got %h exp ff", last_data); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    rxd = 1'b0;
    @(posedge clk);
    #1;
    idle(4 * C);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL glitch_valid got %0d exp 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL glitch_frame_err got %0d exp 0", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy got %b exp 0", rx_busy); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    // Keep the line low long enough that a restarted frame would also fail.
    rxd = 1'b0;
    repeat (12 * C) @(posedge clk);
    #1;
    total_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL ferr_valid got %0d exp 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'hFF) $display("FAIL ferr_data_held got %h exp ff", rx_data); else pass_cnt++;
    total_cnt++; if (rx_busy !== 1'b1) $display("FAIL ferr_wait_high_busy got %b exp 1", rx_busy); else pass_cnt++;
    idle(6);
    total_cnt++; if (rx_busy !== 1'b0) $display("FAIL ferr_recover_busy got %b exp 0", rx_busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0;
    logic [7:0] d;
    d = 8'h81;
    v0 = valid_cnt; f0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rxd = d[4];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(12 * C);
    total_cnt++; if (valid_cnt - v0 !== 0) $display("FAIL rst_mid_valid got %0d exp 0", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL rst_mid_frame_err got %0d exp 0", fe_cnt - f0); else pass_cnt++;
    total_cnt++; if (rx_data !== 8'h00) $display("FAIL rst_mid_data_cleared got %h exp 00", rx_data); else pass_cnt++;
    send_frame(8'h5A, 1'b1);
    idle(2 * C + 4);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL rst_mid_next_valid got %0d exp 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (last_data !== 8'h5A) $display("FAIL rst_mid_next_data got %h exp 5a", last_data); else pass_cnt++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0;
    v0 = valid_cnt;
    send_raw(8'h07, 1'b0, 1'b1);
    idle(2 * C + 4);
    total_cnt++; if (valid_cnt - v0 !== 1) $display("FAIL par_bad_valid got %0d exp 1", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (last_par !== 1'b1) $display("FAIL par_bad_err got %b exp 1", last_par); else pass_cnt++;
    send_raw(8'h07, 1'b1, 1'b1);
    idle(2 * C + 4);
    total_cnt++; if (valid_cnt - v0 !== 2) $display("FAIL par_good_valid got %0d exp 2", valid_cnt - v0); else pass_cnt++;
    total_cnt++; if (last_par !== 1'b0) $display("FAIL par_good_err got %b exp 0", last_par); else pass_cnt++;
    total_cnt++; if (last_data !== 8'h07) $display("FAIL par_data got %h exp 07", last_data); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    total_cnt++; if (both_cnt !== 0) $display("FAIL valid_with_frame_err got %0d exp 0", both_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
